// File: rtl/freq_pkt_pkg.sv
// Shared definitions for the frequency-result frame packer.
// Holds the frame geometry (length, payload length, byte-index map) and the
// FSM state encoding used by freq_frame_packer.
package freq_pkt_pkg;

   localparam int         FRAME_LEN   = 17;
   localparam logic [7:0] PAYLOAD_LEN = 8'h0C;

   // Byte positions within the frame
   localparam logic [4:0] IDX_ID   = 5'd2;
   localparam logic [4:0] IDX_LEN  = 5'd3;
   localparam logic [4:0] IDX_PAY0 = 5'd4;
   localparam logic [4:0] IDX_CHK  = 5'(FRAME_LEN - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/freq_frame_packer.sv
// freq_frame_packer
// Serialises one frequency-measurement result into a 17-byte framed,
// checksummed byte stream over a valid/ready handshake:
//   HDR0 HDR1 PKT_ID LEN res[31:0] high[31:0] low[31:0] CHK (big-endian words)
//   CHK = mod-256 sum of PKT_ID, LEN and the 12 payload bytes.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 request a frame (ignored while busy)
//   freq_res/high/low     32-bit results, latched on an accepted start
//   out_valid/out_data    byte stream towards the FIFO write port
//   out_ready             consumer can take the byte
//   busy                  frame in progress
//   done                  one-cycle pulse after the last byte is accepted
module freq_frame_packer
   import freq_pkt_pkg::*;
#(
   parameter logic [7:0] HDR0   = 8'hA5,
   parameter logic [7:0] HDR1   = 8'h5A,
   parameter logic [7:0] PKT_ID = 8'h03
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] freq_res,
   input  logic [31:0] freq_high,
   input  logic [31:0] freq_low,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   state_t      state;
   logic [4:0]  idx;
   logic [95:0] word;
   logic [7:0]  acc;

   logic        xfer;
   logic [4:0]  idx_nxt;
   logic [7:0]  pay_byte;
   logic [7:0]  next_byte;

   assign xfer    = out_valid && out_ready;
   assign idx_nxt = idx + 5'd1;

   // Payload indices 4..15 map to bytes 11..0 of the latched word (MSB first),
   // i.e. a right shift of 8*(15-idx); idx < 16 there so the low nibble suffices.
   assign pay_byte = 8'(word >> {(4'd15 - idx_nxt[3:0]), 3'b000});

   // out_data is registered, so the byte for the *next* index is prepared here.
   // The checksum byte folds in the byte being accepted now (index 15), which
   // the accumulator has not yet absorbed.
   always_comb begin
      next_byte = pay_byte;
      case (idx_nxt)
         5'd1:    next_byte = HDR1;
         IDX_ID:  next_byte = PKT_ID;
         IDX_LEN: next_byte = PAYLOAD_LEN;
         IDX_CHK: next_byte = acc + out_data;
         default: next_byte = pay_byte;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         word      <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  word      <= {freq_res, freq_high, freq_low};
                  acc       <= '0;
                  idx       <= '0;
                  out_data  <= HDR0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  if (idx == IDX_CHK) begin
                     idx       <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     idx      <= idx_nxt;
                     out_data <= next_byte;
                     if (idx >= IDX_ID)
                        acc <= acc + out_data;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
